// File: rtl/input_ports.sv
// Four-pin input port: 2-flop sync, per-pin debounce, sticky edge flags,
// one-pin-at-a-time read handshake and maskable irq. Define INPUT_PORTS_BOTH_EDGE_EN to flag falling edges too.
module input_ports #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic [1:0] pin,
  input  logic       rd_req,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic       rd_data,
  output logic       rd_flag,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  output logic       irq
);

  localparam int unsigned NPIN = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  logic [NPIN-1:0]  pins_c;
  logic [NPIN-1:0]  s1_q, s2_q;
  logic [NPIN-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [NPIN];
  logic [CNT_W-1:0] cnt_d [NPIN];
  logic [NPIN-1:0]  set_c, clr_c;
  logic [NPIN-1:0]  flag_q, flag_d;
  logic [NPIN-1:0]  mask_q;
  logic             irq_q;
  state_e           state_q, state_d;
  logic             accept_c, ready_d, valid_d;
  logic             ready_q, valid_q, data_q, rflag_q;

  assign pins_c = {D3, D2, D1, D0};

  // Two-flop synchroniser per pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pins_c;
      s2_q <= s1_q;
    end
  end

  // Debounce: the value moves only after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    deb_d = deb_q;
    set_c = '0;
    for (int i = 0; i < NPIN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
`ifdef INPUT_PORTS_BOTH_EDGE_EN
          set_c[i] = 1'b1;
`else
          set_c[i] = s2_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < NPIN; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < NPIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Read FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    accept_c = 1'b0;
    clr_c    = '0;
    ready_d  = (state_d == IDLE);
    valid_d  = (state_d == RESP);
    if (state_q == IDLE && rd_req) begin
      accept_c = 1'b1;
      clr_c    = NPIN'(1) << pin;
    end
  end

  // A simultaneous edge outranks the read's clear
  assign flag_d = (flag_q & ~clr_c) | set_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      rflag_q <= 1'b0;
      flag_q  <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
      if (accept_c) begin
        data_q  <= deb_q[pin];
        rflag_q <= flag_q[pin];
      end
      flag_q <= flag_d;
      if (mask_we) mask_q <= mask_in;
      irq_q <= |(flag_q & mask_q);
    end
  end

  assign rd_ready = ready_q;
  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign rd_flag  = rflag_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_input_ports.sv
// Self-checking bench for input_ports: handshake table, hand-written corner
// sequences and random stimulus against a pin-history reference model.
module tb_input_ports;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d;
  logic [1:0] pin;
  logic       rd_req, mask_we;
  logic [3:0] mask_in;
  logic       rd_ready, rd_valid, rd_data, rd_flag, irq;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_ports #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .pin(pin), .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_flag(rd_flag),
    .mask_we(mask_we), .mask_in(mask_in), .irq(irq)
  );

  // Reference model: a pin's debounced value flips once the last DEB
  // synchronised samples all disagree with it.
  logic [15:0] m_hist [4];
  logic [3:0]  m_s1, m_s2, m_deb, m_flag, m_mask, m_set, m_clr;
  logic        m_busy, m_rdata, m_rflag, m_irq;
  logic [15:0] dm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 4; p++) m_hist[p] = '0;
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_flag = '0; m_mask = '0;
      m_busy = 1'b0; m_rdata = 1'b0; m_rflag = 1'b0; m_irq = 1'b0;
    end else begin
      dm = 16'((1 << DEB) - 1);
      m_set = '0;
      m_clr = '0;
      if (!m_busy && rd_req) begin
        m_rdata = m_deb[pin];
        m_rflag = m_flag[pin];
        m_clr[pin] = 1'b1;
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      m_irq = |(m_flag & m_mask);
      for (int p = 0; p < 4; p++) begin
        m_hist[p] = {m_hist[p][14:0], m_s2[p]};
        if ((m_hist[p] & dm) == (m_deb[p] ? 16'h0 : dm)) begin
          m_deb[p] = ~m_deb[p];
`ifdef INPUT_PORTS_BOTH_EDGE_EN
          m_set[p] = 1'b1;
`else
          m_set[p] = m_deb[p];
`endif
        end
      end
      m_flag = (m_flag & ~m_clr) | m_set;
      if (mask_we) m_mask = mask_in;
      m_s2 = m_s1;
      m_s1 = d;
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_chk();
    chk("model rd_ready", 4'(rd_ready), 4'(!m_busy));
    chk("model rd_valid", 4'(rd_valid), 4'(m_busy));
    chk("model rd_data",  4'(rd_data),  4'(m_rdata));
    chk("model rd_flag",  4'(rd_flag),  4'(m_rflag));
    chk("model irq",      4'(irq),      4'(m_irq));
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      model_chk();
    end
  endtask

  task automatic do_reset();
    rd_req = 1'b0; mask_we = 1'b0; mask_in = '0; pin = '0; d = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  typedef struct {
    logic       req;
    logic [1:0] pin;
    logic       exp_ready;
    logic       exp_valid;
  } hs_vec_t;

  hs_vec_t hs_tab [5];
  int      nval;
  logic    exp_both;

  initial begin
    hs_tab[0] = '{1'b1, 2'd2, 1'b0, 1'b1};
    hs_tab[1] = '{1'b1, 2'd2, 1'b1, 1'b0};
    hs_tab[2] = '{1'b1, 2'd2, 1'b0, 1'b1};
    hs_tab[3] = '{1'b1, 2'd2, 1'b1, 1'b0};
    hs_tab[4] = '{1'b0, 2'd0, 1'b1, 1'b0};

    // Reset with all pins high
    rd_req = 1'b0; mask_we = 1'b0; mask_in = '0; pin = '0;
    d = 4'hF; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rd_ready", 4'(rd_ready), 4'h1);
    chk("reset rd_valid", 4'(rd_valid), 4'h0);
    chk("reset irq",      4'(irq),      4'h0);
    rst_n = 1'b1;
    step(1);
    rd_req = 1'b1; pin = 2'd2;
    step(1);
    rd_req = 1'b0;
    chk("post-reset read valid", 4'(rd_valid), 4'h1);
    chk("post-reset read data",  4'(rd_data),  4'h0);
    chk("post-reset read flag",  4'(rd_flag),  4'h0);
    step(1);

    // Reset while in RESP drops the strobe immediately
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    chk("resp before abort", 4'(rd_valid), 4'h1);
    rst_n = 1'b0;
    #1;
    chk("abort rd_valid", 4'(rd_valid), 4'h0);
    chk("abort rd_ready", 4'(rd_ready), 4'h1);

    // Debounce latency with continuous reads of pin 1
    do_reset();
    d[1] = 1'b1; rd_req = 1'b1; pin = 2'd1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      if (k == 5) begin
        chk("deb read@5 data", 4'(rd_data), 4'h0);
        chk("deb read@5 flag", 4'(rd_flag), 4'h0);
      end
      if (k == 7) begin
        chk("deb read@7 data", 4'(rd_data), 4'h1);
        chk("deb read@7 flag", 4'(rd_flag), 4'h1);
      end
      if (k == 9) begin
        chk("deb read@9 data", 4'(rd_data), 4'h1);
        chk("deb read@9 flag", 4'(rd_flag), 4'h0);
      end
    end
    rd_req = 1'b0;
    step(1);

    // Three-cycle glitch on D0 is rejected
    do_reset();
    mask_in = 4'hF; mask_we = 1'b1;
    step(1);
    mask_we = 1'b0;
    d[0] = 1'b1;
    step(3);
    d[0] = 1'b0;
    step(8);
    chk("glitch irq", 4'(irq), 4'h0);
    rd_req = 1'b1; pin = 2'd0;
    step(1);
    rd_req = 1'b0;
    chk("glitch data", 4'(rd_data), 4'h0);
    chk("glitch flag", 4'(rd_flag), 4'h0);

    // Interrupt on masked pin 3
    do_reset();
    mask_in = 4'h8; mask_we = 1'b1;
    step(1);
    mask_we = 1'b0;
    d[3] = 1'b1;
    step(6);
    chk("irq before flag+1", 4'(irq), 4'h0);
    step(1);
    chk("irq after flag", 4'(irq), 4'h1);
    rd_req = 1'b1; pin = 2'd3;
    step(1);
    rd_req = 1'b0;
    chk("irq read flag", 4'(rd_flag), 4'h1);
    chk("irq held on read edge", 4'(irq), 4'h1);
    step(1);
    chk("irq dropped", 4'(irq), 4'h0);

    // Handshake table
    do_reset();
    chk("hs initial ready", 4'(rd_ready), 4'h1);
    nval = 0;
    for (int i = 0; i < 5; i++) begin
      rd_req = hs_tab[i].req; pin = hs_tab[i].pin;
      step(1);
      chk("hs rd_ready", 4'(rd_ready), 4'(hs_tab[i].exp_ready));
      chk("hs rd_valid", 4'(rd_valid), 4'(hs_tab[i].exp_valid));
      if (rd_valid) nval++;
    end
    chk("hs strobe count", 4'(nval), 4'h2);

    // Set/clear collision on pin 2
    do_reset();
    d[2] = 1'b1;
    step(5);
    rd_req = 1'b1; pin = 2'd2;
    step(1);
    rd_req = 1'b0;
    chk("collide flag", 4'(rd_flag), 4'h0);
    chk("collide data", 4'(rd_data), 4'h0);
    step(1);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    chk("after collide flag", 4'(rd_flag), 4'h1);
    chk("after collide data", 4'(rd_data), 4'h1);
    d[2] = 1'b0;
    step(8);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
`ifdef INPUT_PORTS_BOTH_EDGE_EN
    exp_both = 1'b1;
`else
    exp_both = 1'b0;
`endif
    chk("fall flag", 4'(rd_flag), 4'(exp_both));
    chk("fall data", 4'(rd_data), 4'h0);
    step(1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(7, 0) == 0) d[p] = ~d[p];
      rd_req  = 1'($urandom_range(1, 0));
      pin     = 2'($urandom_range(3, 0));
      mask_we = ($urandom_range(9, 0) == 0);
      mask_in = 4'($urandom_range(15, 0));
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
